// File: rtl/sfp_pkg.sv
// Shared definitions for the sfp arithmetic blocks (sfp_mult, sfp_div):
// self-format field layout, FSM state encoding and special-operand classes.
package sfp_pkg;

  localparam int SFP_W   = 26;
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 17;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  // Field slices of a self-format word: [SIGN_BIT] [EXP_HI:EXP_LO] [MAN_HI:MAN_LO]
  localparam int SIGN_BIT = SFP_W - 1;
  localparam int EXP_HI   = SFP_W - 2;
  localparam int EXP_LO   = MAN_W;
  localparam int MAN_HI   = MAN_W - 1;
  localparam int MAN_LO   = 0;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    NORM
  } sfp_state_e;

  typedef enum logic [1:0] {
    SPEC_NONE,
    SPEC_ZERO,
    SPEC_INF,
    SPEC_DZ
  } sfp_spec_e;

endpackage

// File: rtl/sfp_div_core.sv
// Iterative restoring mantissa divider: one quotient bit per cycle, QW steps,
// producing floor(ma * 2^(QW-1) / mb) and a non-zero-remainder flag.
module sfp_div_core #(
  parameter int MW = 18,
  parameter int QW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [MW-1:0] ma,
  input  logic [MW-1:0] mb,
  output logic [QW-1:0] q,
  output logic          rem_nz,
  output logic          done
);

  localparam int CW = $clog2(QW);

  logic [MW:0]   rem_q, rem_d, rem_sub;
  logic [MW-1:0] div_q, div_d;
  logic [QW-1:0] q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic          ge;

  always_comb begin
    ge      = rem_q >= {1'b0, div_q};
    rem_sub = rem_q - {1'b0, div_q};
    rem_d   = rem_q;
    div_d   = div_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    if (start) begin
      rem_d = {1'b0, ma};
      div_d = mb;
      q_d   = '0;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      // remainder stays below the divisor, so the shift never loses a bit
      rem_d = (ge ? rem_sub : rem_q) << 1;
      q_d   = {q_q[QW-2:0], ge};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(QW - 1)) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      div_q <= '0;
      q_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      rem_q <= rem_d;
      div_q <= div_d;
      q_q   <= q_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

  // done marks the final step: q and rem_nz are complete after this edge
  assign done   = run_q && (cnt_q == CW'(QW - 1));
  assign q      = q_q;
  assign rem_nz = |rem_q;

endmodule

// File: rtl/sfp_div.sv
// Self-format floating-point divider, 22-cycle fixed latency with busy flag.
// Define SFP_DIV_ROUND_EN for round-to-nearest-even; default build truncates.
module sfp_div #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 17
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req,
  input  logic [EXP_W+MAN_W:0] i_da,
  input  logic [EXP_W+MAN_W:0] i_db,
  output logic                 o_vld,
  output logic [EXP_W+MAN_W:0] o_do,
  output logic                 o_dz,
  output logic                 o_busy
);

  import sfp_pkg::*;

  localparam int SW = EXP_W + MAN_W + 1;
  localparam int MW = MAN_W + 1;
  localparam int QW = MAN_W + 3;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS_S = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_W) - 1);

  sfp_state_e            state_q, state_d;
  sfp_spec_e             spec_q, spec_d, spec_in;
  logic                  sign_q, sign_d;
  logic signed [EW-1:0]  exp_q, exp_d;
  logic                  busy_q, busy_d;
  logic                  vld_q, vld_d;
  logic                  dz_q, dz_d;
  logic [SW-1:0]         dout_q, dout_d;

  logic [EXP_W-1:0]      ea, eb;
  logic signed [EW-1:0]  ea_s, eb_s;
  logic [MW-1:0]         ma, mb;
  logic                  start;
  logic [QW-1:0]         core_q;
  logic                  core_rem_nz;
  logic                  core_done;

  logic [MAN_W-1:0]      frac_n, frac_r;
  logic                  guard, sticky;
  logic signed [EW-1:0]  exp_n, exp_r;
  logic [SW-1:0]         res;
`ifdef SFP_DIV_ROUND_EN
  logic                  inc;
  logic [MAN_W:0]        frac_sum;
`else
  logic                  unused_round;
`endif

  assign ea   = i_da[SW-2 -: EXP_W];
  assign eb   = i_db[SW-2 -: EXP_W];
  assign ea_s = {{(EW - EXP_W){1'b0}}, ea};
  assign eb_s = {{(EW - EXP_W){1'b0}}, eb};
  assign ma   = {1'b1, i_da[MAN_W-1:0]};
  assign mb   = {1'b1, i_db[MAN_W-1:0]};

  sfp_div_core #(
    .MW(MW),
    .QW(QW)
  ) u_core (
    .clk   (i_clk),
    .rst_n (i_rst),
    .start (start),
    .ma    (ma),
    .mb    (mb),
    .q     (core_q),
    .rem_nz(core_rem_nz),
    .done  (core_done)
  );

  // Divisor zero wins over everything, so 0/0 reports divide-by-zero.
  always_comb begin
    spec_in = SPEC_NONE;
    if (eb == '0) begin
      spec_in = SPEC_DZ;
    end else if (ea == '0) begin
      spec_in = SPEC_ZERO;
    end else if (ea == '1) begin
      spec_in = SPEC_INF;
    end else if (eb == '1) begin
      spec_in = SPEC_ZERO;
    end
  end

  always_comb begin
    if (core_q[QW-1]) begin
      frac_n = core_q[QW-2:2];
      guard  = core_q[1];
      sticky = core_q[0] | core_rem_nz;
      exp_n  = exp_q;
    end else begin
      frac_n = core_q[QW-3:1];
      guard  = core_q[0];
      sticky = core_rem_nz;
      exp_n  = exp_q - EW'(1);
    end
`ifdef SFP_DIV_ROUND_EN
    inc      = guard & (sticky | frac_n[0]);
    frac_sum = {1'b0, frac_n} + {{MAN_W{1'b0}}, inc};
    frac_r   = frac_sum[MAN_W-1:0];
    exp_r    = frac_sum[MAN_W] ? exp_n + EW'(1) : exp_n;
`else
    unused_round = guard ^ sticky;
    frac_r       = frac_n;
    exp_r        = exp_n;
`endif
    case (spec_q)
      SPEC_DZ, SPEC_INF: res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      SPEC_ZERO:         res = {sign_q, {(EXP_W + MAN_W){1'b0}}};
      default: begin
        if (exp_r[EW-1] || exp_r == '0) begin
          res = {sign_q, {(EXP_W + MAN_W){1'b0}}};
        end else if (exp_r >= EMAX_S) begin
          res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
          res = {sign_q, exp_r[EXP_W-1:0], frac_r};
        end
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    spec_d  = spec_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    busy_d  = busy_q;
    vld_d   = 1'b0;
    dz_d    = dz_q;
    dout_d  = dout_q;
    start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          state_d = CALC;
          busy_d  = 1'b1;
          start   = 1'b1;
          sign_d  = i_da[SW-1] ^ i_db[SW-1];
          exp_d   = ea_s - eb_s + BIAS_S;
          spec_d  = spec_in;
        end
      end
      CALC: begin
        if (core_done) begin
          state_d = NORM;
        end
      end
      NORM: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        vld_d   = 1'b1;
        dout_d  = res;
        dz_d    = (spec_q == SPEC_DZ);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      spec_q  <= SPEC_NONE;
      sign_q  <= 1'b0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      dz_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      spec_q  <= spec_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
      dz_q    <= dz_d;
      dout_q  <= dout_d;
    end
  end

  assign o_vld  = vld_q;
  assign o_do   = dout_q;
  assign o_dz   = dz_q;
  assign o_busy = busy_q;

endmodule
